// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the five-stage RV32I core: stall/flush enables,
// E-stage forwarding selects and multi-cycle divide sequencing.
module hazard_ctrl #(
  parameter int DIV_LATENCY = 4,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              load_d,
  input  logic              pc_src_e,
  input  logic              div_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              stall_e,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              load;
  } slot_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_e;

  localparam logic [2:0] LAST_CNT  = 3'(DIV_LATENCY - 1);
  localparam logic       MULTI_DIV = (DIV_LATENCY > 1);
  localparam slot_t      BUBBLE    = '0;

  slot_t             e_q, e_d, m_q, m_d, w_q, w_d;
  logic [REG_AW-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
  div_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic div_start, div_busy, lu, br;

  // The load flag only matters in E; M and W carry it for completeness.
  logic unused_load;
  assign unused_load = m_q.load ^ w_q.load;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input slot_t m, input slot_t w);
    if (m.valid && m.reg_write && (m.rd != '0) && (m.rd == rs))
      return 2'b10;
    else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    div_start = (state_q == IDLE) && e_q.valid && div_e && MULTI_DIV;
    div_busy  = div_start || ((state_q == BUSY) && (cnt_q < LAST_CNT));
    lu = valid_d && e_q.valid && e_q.load && (e_q.rd != '0) &&
         ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    br = pc_src_e && e_q.valid && !div_busy;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (div_start) begin
        state_d = BUSY;
        cnt_d   = 3'd1;
      end
      BUSY: if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // A divide freezes E and drains a bubble into M; branch/load-use kill E.
  always_comb begin
    e_d     = {valid_d, rd_d, reg_write_d, load_d};
    rs1_e_d = rs1_d;
    rs2_e_d = rs2_d;
    m_d     = e_q;
    w_d     = m_q;
    if (div_busy) begin
      e_d     = e_q;
      rs1_e_d = rs1_e_q;
      rs2_e_d = rs2_e_q;
      m_d     = BUBBLE;
    end else if (br || lu) begin
      e_d     = BUBBLE;
      rs1_e_d = '0;
      rs2_e_d = '0;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (reset) begin
      fwd_a_e = fwd_sel(rs1_e_q, m_q, w_q);
      fwd_b_e = fwd_sel(rs2_e_q, m_q, w_q);
      if (div_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (br) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q     <= BUBBLE;
      m_q     <= BUBBLE;
      w_q     <= BUBBLE;
      rs1_e_q <= '0;
      rs2_e_q <= '0;
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      rs1_e_q <= rs1_e_d;
      rs2_e_q <= rs2_e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios with literal
// expectations, then randomized traffic against a pipeline-level model.
module tb_hazard_ctrl;

  localparam int DIV_LATENCY = 4;
  localparam int REG_AW      = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_d, reg_write_d, load_d, pc_src_e, div_e;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic              stall_f, stall_d, flush_d, stall_e, flush_e, flush_m;
  logic [1:0]        fwd_a_e, fwd_b_e;

  hazard_ctrl #(.DIV_LATENCY(DIV_LATENCY), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_src_e(pc_src_e), .div_e(div_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              valid;
    bit [REG_AW-1:0] rd, rs1, rs2;
    bit              rw, ld, is_div;
  } instr_t;

  // pipe[0] = E, pipe[1] = M, pipe[2] = W
  instr_t pipe[3];
  instr_t nxt[3];
  instr_t dec;
  instr_t bubble;
  int     e_age, nxt_age;
  bit     hold_d;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_output(input string name, input logic [1:0] act,
                              input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input bit [REG_AW-1:0] rs);
    if (pipe[1].valid && pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].valid && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Every falling edge: predict outputs from the model, compare, plan next state.
  always @(negedge clk) begin
    bit busy, lu, br;
    bit [5:0] ctl;
    logic [1:0] fa, fb;
    busy = pipe[0].valid && pipe[0].is_div && DIV_LATENCY > 1 && e_age < DIV_LATENCY;
    lu   = dec.valid && pipe[0].valid && pipe[0].ld && pipe[0].rd != 0 &&
           (pipe[0].rd == dec.rs1 || pipe[0].rd == dec.rs2);
    br   = pc_src_e && pipe[0].valid && !busy;
    // ctl = {stall_f, stall_d, flush_d, stall_e, flush_e, flush_m}
    if (busy)    ctl = 6'b110101;
    else if (br) ctl = 6'b001010;
    else if (lu) ctl = 6'b110010;
    else         ctl = 6'b000000;
    fa = fwd_model(pipe[0].rs1);
    fb = fwd_model(pipe[0].rs2);
    if (!reset) begin
      ctl = '0;
      fa  = 2'b00;
      fb  = 2'b00;
    end
    check_output("stall_f", {1'b0, stall_f}, {1'b0, ctl[5]});
    check_output("stall_d", {1'b0, stall_d}, {1'b0, ctl[4]});
    check_output("flush_d", {1'b0, flush_d}, {1'b0, ctl[3]});
    check_output("stall_e", {1'b0, stall_e}, {1'b0, ctl[2]});
    check_output("flush_e", {1'b0, flush_e}, {1'b0, ctl[1]});
    check_output("flush_m", {1'b0, flush_m}, {1'b0, ctl[0]});
    check_output("fwd_a_e", fwd_a_e, fa);
    check_output("fwd_b_e", fwd_b_e, fb);
    hold_d = ctl[4];
    nxt[2] = pipe[1];
    nxt[1] = busy ? bubble : pipe[0];
    if (busy)           nxt[0] = pipe[0];
    else if (br || lu)  nxt[0] = bubble;
    else                nxt[0] = dec;
    nxt_age = busy ? e_age + 1 : 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) pipe[i] <= bubble;
      e_age <= 0;
    end else begin
      for (int i = 0; i < 3; i++) pipe[i] <= nxt[i];
      e_age <= nxt_age;
    end
  end

  // Drive one decode instruction; div_e reflects whatever occupies E.
  task automatic apply_stimulus(input bit v, input int rd, input int r1, input int r2,
                                input bit rw, input bit ld, input bit dv, input bit pc);
    dec.valid  = v;
    dec.rd     = REG_AW'(rd);
    dec.rs1    = REG_AW'(r1);
    dec.rs2    = REG_AW'(r2);
    dec.rw     = rw;
    dec.ld     = ld;
    dec.is_div = dv;
    valid_d     = dec.valid;
    rd_d        = dec.rd;
    rs1_d       = dec.rs1;
    rs2_d       = dec.rs2;
    reg_write_d = dec.rw;
    load_d      = dec.ld;
    pc_src_e    = pc;
    div_e       = pipe[0].valid ? pipe[0].is_div : 1'($urandom_range(0, 1));
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bubble = '{default: 0};
    dec    = '{default: 0};
    reset = 1'b1;
    valid_d = 0; rd_d = 0; rs1_d = 0; rs2_d = 0;
    reg_write_d = 0; load_d = 0; pc_src_e = 0; div_e = 0;
    #1 reset = 1'b0;
    #2;
    check_output("reset_stall_f", {1'b0, stall_f}, 2'd0);
    check_output("reset_fwd_a", fwd_a_e, 2'b00);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    next_cycle();

    // Load-use: lw x5 then add rs1=5
    apply_stimulus(1, 5, 0, 0, 1, 1, 0, 0);
    check_output("lu_pre_stall_d", {1'b0, stall_d}, 2'd0);
    next_cycle();
    apply_stimulus(1, 6, 5, 7, 1, 0, 0, 0);
    check_output("lu_stall_f", {1'b0, stall_f}, 2'd1);
    check_output("lu_stall_d", {1'b0, stall_d}, 2'd1);
    check_output("lu_flush_e", {1'b0, flush_e}, 2'd1);
    next_cycle();
    apply_stimulus(1, 6, 5, 7, 1, 0, 0, 0);
    check_output("lu_after_stall_d", {1'b0, stall_d}, 2'd0);
    check_output("lu_after_flush_e", {1'b0, flush_e}, 2'd0);
    next_cycle();
    // add x3 enters decode; the add with rs1=5 sits in E with lw in W
    apply_stimulus(1, 3, 1, 2, 1, 0, 0, 0);
    check_output("lu_fwd_w", fwd_a_e, 2'b01);
    next_cycle();
    apply_stimulus(1, 3, 1, 2, 1, 0, 0, 0);
    next_cycle();
    apply_stimulus(1, 4, 3, 3, 1, 0, 0, 0);
    next_cycle();
    // or x4,x3,x3 in E, sub x3 in M, add x3 in W; a divide enters decode
    apply_stimulus(1, 7, 1, 2, 1, 0, 1, 0);
    check_output("prio_fwd_a", fwd_a_e, 2'b10);
    check_output("prio_fwd_b", fwd_b_e, 2'b10);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("div1_stall_e", {1'b0, stall_e}, 2'd1);
    check_output("div1_flush_m", {1'b0, flush_m}, 2'd1);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("div2_flush_d", {1'b0, flush_d}, 2'd0);
    check_output("div2_stall_e", {1'b0, stall_e}, 2'd1);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("div3_stall_e", {1'b0, stall_e}, 2'd1);
    next_cycle();
    apply_stimulus(1, 8, 1, 2, 1, 0, 1, 0);
    check_output("div4_free", {1'b0, stall_e}, 2'd0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("bdiv1_stall_e", {1'b0, stall_e}, 2'd1);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("bdiv3_stall_e", {1'b0, stall_e}, 2'd1);
    // Reset in the middle of the divide
    #2 reset = 1'b0;
    #1;
    check_output("rst_mid_stall_e", {1'b0, stall_e}, 2'd0);
    check_output("rst_mid_stall_f", {1'b0, stall_f}, 2'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    next_cycle();

    // x0 writers never cause stalls or forwarding
    apply_stimulus(1, 0, 0, 0, 1, 1, 0, 0);
    next_cycle();
    apply_stimulus(1, 1, 0, 0, 1, 0, 0, 0);
    check_output("x0_no_stall", {1'b0, stall_d}, 2'd0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("x0_fwd_a", fwd_a_e, 2'b00);
    next_cycle();

    // Branch overrides a pending load-use
    apply_stimulus(1, 9, 0, 0, 1, 1, 0, 0);
    next_cycle();
    apply_stimulus(1, 2, 9, 0, 1, 0, 0, 1);
    check_output("br_flush_d", {1'b0, flush_d}, 2'd1);
    check_output("br_flush_e", {1'b0, flush_e}, 2'd1);
    check_output("br_stall_d", {1'b0, stall_d}, 2'd0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("br_bubble_fwd", fwd_a_e, 2'b00);
    next_cycle();

    // Randomized traffic; decode holds its instruction while stalled
    for (int c = 0; c < 3000; c++) begin
      if (hold_d)
        apply_stimulus(dec.valid, dec.rd, dec.rs1, dec.rs2, dec.rw, dec.ld, dec.is_div,
                       ($urandom_range(0, 7) == 0));
      else begin
        bit rw;
        rw = ($urandom_range(0, 9) < 7);
        apply_stimulus(($urandom_range(0, 9) < 8), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7), rw,
                       rw && ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 7) == 0));
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
